// File: rtl/core_pkg.sv
// Shared types for the FP issue controller: register bank selector,
// issue FSM states and the tag recorded for every op handed to the FPU.
package core_pkg;

  typedef enum logic {
    X_REG = 1'b0,
    F_REG = 1'b1
  } reg_bank_mux_t;

  typedef enum logic [1:0] {
    FPU_IDLE  = 2'd0,
    FPU_BUSY  = 2'd1,
    FPU_DRAIN = 2'd2
  } fpu_issue_state_t;

  typedef struct packed {
    logic          live;
    logic [4:0]    rd_addr;
    reg_bank_mux_t bank;
  } fpu_tag_t;

  localparam int TAG_W = $bits(fpu_tag_t);

  // True when a live in-flight destination matches an ID source; x0 never
  // carries a dependency, so it is excluded.
  function automatic logic tag_hits_src(fpu_tag_t tag, logic [4:0] rs_addr,
                                        reg_bank_mux_t rs_bank);
    return tag.live && (tag.rd_addr == rs_addr) && (tag.bank == rs_bank) &&
           !((rs_bank == X_REG) && (rs_addr == 5'd0));
  endfunction

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order tag FIFO for ops issued to the FPU. Exposes the head, fill level
// and all entries ordered oldest-first so the top can compare every
// in-flight destination. Popped slots have their live bit cleared so stale
// storage never looks like an in-flight op.
module fpu_tag_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_data,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*TAG_W-1:0]   entries,
  output logic [DEPTH-1:0]         occupied
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  fpu_tag_t      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and fill level; a pop retires the head slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_ONE;
      end
      if (do_push) begin
        mem[wr_ptr] <= fpu_tag_t'(push_data);
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Present entries oldest-first with an occupancy mask
  always_comb begin
    entries  = '0;
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*TAG_W +: TAG_W] = mem[rd_ptr + AW'(i)];
      occupied[i]               = ((AW+1)'(i) < count);
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: runs the req/gnt/rvalid handshake between ID and the
// shared FPU, tracks in-flight destinations in a tag FIFO, raises RAW stalls
// on live in-flight destinations and steers FPU results to writeback.
// Optional build macro FPU_ISSUE_PERF_EN adds three 32-bit wrapping
// performance counters (grant stalls, busy cycles, killed pops).
module fpu_issue_ctrl
  import core_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        fpu_op_valid_id_i,
  input  logic        flush_id_i,
  input  logic        fpu_op_ex_i,
  input  logic [4:0]  rd_addr_id_i,
  input  logic        rd_dst_bank_id_i,
  input  logic [4:0]  rs1_addr_id_i,
  input  logic [4:0]  rs2_addr_id_i,
  input  logic [4:0]  rs3_addr_id_i,
  input  logic        rs1_src_bank_id_i,
  input  logic        rs2_src_bank_id_i,
  input  logic        rs3_src_bank_id_i,
  output logic        fpu_req_id_o,
  output logic        fpu_gnt_id_o,
  output logic        fpu_busy_ex_o,
  output logic        fpu_raw_stall_o,
  output logic        apu_req_o,
  input  logic        apu_gnt_i,
  input  logic        apu_rvalid_i,
  output logic        fpu_wb_valid_o,
  output logic [4:0]  fpu_wb_rd_addr_o,
  output logic        fpu_wb_bank_o,
  output logic        fpu_proto_err_o
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_gnt_stall_o,
  output logic [31:0] perf_busy_o,
  output logic [31:0] perf_killed_o
`endif
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO = (AW+1)'(2);

  fpu_issue_state_t state;
  fpu_issue_state_t state_next;
  fpu_tag_t         push_tag;
  fpu_tag_t         head_tag;
  fpu_tag_t         entry [MAX_OUTSTANDING];
  logic [TAG_W-1:0] head_flat;
  logic [MAX_OUTSTANDING*TAG_W-1:0] entries_flat;
  logic [MAX_OUTSTANDING-1:0]       occupied;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_live;
  logic             any_live;
  logic             raw_stall;
  logic             next_head_live;
  logic             proto_err;

  assign push_tag = '{live:    !flush_id_i,
                      rd_addr: rd_addr_id_i,
                      bank:    reg_bank_mux_t'(rd_dst_bank_id_i)};

  assign fpu_req_id_o     = fpu_op_valid_id_i;
  assign apu_req_o        = fpu_op_valid_id_i & !full & !raw_stall;
  assign fpu_gnt_id_o     = apu_req_o & apu_gnt_i;
  assign push             = fpu_gnt_id_o;
  assign pop              = apu_rvalid_i & !empty;
  assign head_tag         = fpu_tag_t'(head_flat);
  assign head_live        = !empty & head_tag.live;
  assign fpu_raw_stall_o  = raw_stall;
  assign fpu_wb_valid_o   = pop & head_tag.live;
  assign fpu_wb_rd_addr_o = fpu_wb_valid_o ? head_tag.rd_addr : 5'd0;
  assign fpu_wb_bank_o    = fpu_wb_valid_o & (head_tag.bank == F_REG);
  assign fpu_busy_ex_o    = fpu_op_ex_i & any_live &
                            !(apu_rvalid_i & head_live & (count == CNT_ONE));
  assign fpu_proto_err_o  = proto_err;

  fpu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (push),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head_flat),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .entries   (entries_flat),
    .occupied  (occupied)
  );

  for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_unpack
    assign entry[g] = fpu_tag_t'(entries_flat[g*TAG_W +: TAG_W]);
  end

  // RAW detection against live in-flight entries; the retiring head is exempt
  always_comb begin
    raw_stall = 1'b0;
    any_live  = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (occupied[i] && entry[i].live) begin
        any_live = 1'b1;
        if (!((i == 0) && pop) &&
            (tag_hits_src(entry[i], rs1_addr_id_i, reg_bank_mux_t'(rs1_src_bank_id_i)) ||
             tag_hits_src(entry[i], rs2_addr_id_i, reg_bank_mux_t'(rs2_src_bank_id_i)) ||
             tag_hits_src(entry[i], rs3_addr_id_i, reg_bank_mux_t'(rs3_src_bank_id_i))))
          raw_stall = 1'b1;
      end
    end
  end

  // Fill level and head liveness as they will be after this cycle's push/pop
  always_comb begin
    count_next     = count;
    next_head_live = head_tag.live;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (pop && !push) count_next = count - CNT_ONE;
    if (pop)        next_head_live = (count >= CNT_TWO) ? entry[1].live : push_tag.live;
    else if (empty) next_head_live = push_tag.live;
  end

  // Issue FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= FPU_IDLE;
    else          state <= state_next;
  end

  // Issue FSM next state, following the FIFO contents after push/pop
  always_comb begin
    state_next = state;
    case (state)
      FPU_IDLE: begin
        if (push) state_next = push_tag.live ? FPU_BUSY : FPU_DRAIN;
      end
      FPU_BUSY, FPU_DRAIN: begin
        if (count_next == '0) state_next = FPU_IDLE;
        else if (pop)         state_next = next_head_live ? FPU_BUSY : FPU_DRAIN;
      end
      default: state_next = FPU_IDLE;
    endcase
  end

  // Sticky flag for a result arriving with nothing outstanding
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                   proto_err <= 1'b0;
    else if (apu_rvalid_i && empty) proto_err <= 1'b1;
  end

`ifdef FPU_ISSUE_PERF_EN
  // Wrapping event counters for grant stalls, EX busy cycles and killed pops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_gnt_stall_o <= 32'd0;
      perf_busy_o      <= 32'd0;
      perf_killed_o    <= 32'd0;
    end else begin
      if (fpu_req_id_o && !fpu_gnt_id_o) perf_gnt_stall_o <= perf_gnt_stall_o + 32'd1;
      if (fpu_busy_ex_o)                 perf_busy_o      <= perf_busy_o + 32'd1;
      if (pop && !head_tag.live)         perf_killed_o    <= perf_killed_o + 32'd1;
    end
  end
`endif

endmodule
